// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage <-> hazard controller bundle.
// master = ID stage, slave = hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [RA_W-1:0]  id_rs;
  logic [RA_W-1:0]  id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_wreg;
  logic             id_m2reg;
  logic [RA_W-1:0]  id_rn;
  logic             br_taken;
  logic             stall;
  logic             bubble;
  logic             flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt,
    output id_use_rs, id_use_rt,
    output id_wreg, id_m2reg, id_rn,
    output br_taken,
    input  stall, bubble, flush,
    input  fwd_a, fwd_b,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt,
    input  id_use_rs, id_use_rt,
    input  id_wreg, id_m2reg, id_rn,
    input  br_taken,
    output stall, bubble, flush,
    output fwd_a, fwd_b,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller with in-flight writer scoreboard,
// branch flush countdown and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int RA_W       = 5,
  parameter int LOAD_LAT   = 1,
  parameter int FWD_EN     = 1,
  parameter int BR_PENALTY = 1,
  parameter int CNT_W      = 16
) (
  input logic               i_clk,
  input logic               i_rst,
  pipe_hazard_ctrl_if.slave hif
);
  localparam int L = LOAD_LAT;

  logic [L:0]           r_v;
  logic [L:0]           r_ld;
  logic [L:0][RA_W-1:0] r_rn;
  logic [1:0]           r_fdown;
  logic [CNT_W-1:0]     r_scnt;
  logic [CNT_W-1:0]     r_fcnt;

  logic       w_flush;
  logic       w_valid;
  logic       w_stall;
  logic       w_bubble;
  logic [2:0] w_la;
  logic [2:0] w_lb;

  // {stall, sel}; walk oldest to youngest so the youngest match wins.
  function automatic logic [2:0] f_lookup(
    input logic            use_r,
    input logic [RA_W-1:0] ra
  );
    logic [2:0] res;
    res = 3'b000;
    for (int i = L; i >= 0; i--) begin
      if (use_r && r_v[i] && r_rn[i] != '0 && r_rn[i] == ra) begin
        if (FWD_EN == 0)            res = 3'b100;
        else if (r_ld[i] && i == L) res = 3'b011;
        else if (r_ld[i])           res = 3'b100;
        else if (i == 0)            res = 3'b001;
        else if (i == 1)            res = 3'b010;
        else                        res = 3'b100;
      end
    end
    return res;
  endfunction

  always_comb begin
    w_flush  = (r_fdown != 2'd0);
    w_valid  = hif.id_valid & ~w_flush;
    w_la     = f_lookup(hif.id_use_rs, hif.id_rs);
    w_lb     = f_lookup(hif.id_use_rt, hif.id_rt);
    w_stall  = w_valid & (w_la[2] | w_lb[2]);
    w_bubble = w_stall | w_flush;
  end

  assign hif.stall     = w_stall;
  assign hif.bubble    = w_bubble;
  assign hif.flush     = w_flush;
  assign hif.fwd_a     = w_valid ? w_la[1:0] : 2'd0;
  assign hif.fwd_b     = w_valid ? w_lb[1:0] : 2'd0;
  assign hif.stall_cnt = r_scnt;
  assign hif.flush_cnt = r_fcnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v     <= '0;
      r_ld    <= '0;
      r_rn    <= '0;
      r_fdown <= '0;
      r_scnt  <= '0;
      r_fcnt  <= '0;
    end else begin
      r_v  <= {r_v[L-1:0],
               hif.id_valid & hif.id_wreg & ~w_bubble};
      r_ld <= {r_ld[L-1:0], hif.id_m2reg};
      r_rn <= {r_rn[L-1:0], hif.id_rn};
      if (hif.br_taken && !w_stall && !w_flush)
        r_fdown <= 2'(BR_PENALTY);
      else if (w_flush)
        r_fdown <= r_fdown - 2'd1;
      if (w_stall && r_scnt != '1)
        r_scnt <= r_scnt + CNT_W'(1);
      if (w_flush && r_fcnt != '1)
        r_fcnt <= r_fcnt + CNT_W'(1);
    end
  end
endmodule
